// File: rtl/lstm_seq_ctrl_if.sv
// Control/status bundle between the LSTM array top level and its sequencer.
// Latency: wires only.
// Backpressure: none; the sequencer has no ready path, requests are sampled per cycle.
interface lstm_seq_ctrl_if #(
  parameter int WIDTH = 32
);
  logic             i_start;
  logic             i_abort;
  logic             i_upd;
  logic [WIDTH-1:0] o_addr;
  logic             o_shift_en;
  logic             o_commit;
  logic             o_h_valid;
  logic [WIDTH-1:0] o_step;
  logic             o_sel;
  logic             o_busy;
  logic             o_done;

  modport master (
    output i_start, i_abort, i_upd,
    input  o_addr, o_shift_en, o_commit, o_h_valid, o_step, o_sel, o_busy, o_done
  );

  modport slave (
    input  i_start, i_abort, i_upd,
    output o_addr, o_shift_en, o_commit, o_h_valid, o_step, o_sel, o_busy, o_done
  );
endinterface

// File: rtl/lstm_seq_ctrl.sv
// Sequencer for the LSTM forward array: input address, shift enable, state commit and weight select.
// Latency: first address 1 cycle after start; step s captures at start+P*(s+1), P = NUM+LSTM_LAT; run is NUM_ITERATIONS*P+1 cycles.
// Backpressure: none; a run free-runs once accepted and only i_abort or rst end it early.
module lstm_seq_ctrl #(
  parameter int WIDTH          = 32,
  parameter int NUM            = 69,
  parameter int NUM_ITERATIONS = 8,
  parameter int LSTM_LAT       = 4
) (
  input logic            clk,
  input logic            rst,
  lstm_seq_ctrl_if.slave bus
);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    LOAD    = 3'd1,
    SETTLE  = 3'd2,
    CAPTURE = 3'd3,
    DONE    = 3'd4
  } state_t;

  // Terminal counts for the per-phase counters.
  localparam logic [WIDTH-1:0] ELEM_LAST = WIDTH'(NUM - 2);
  localparam logic [WIDTH-1:0] LAT_LAST  = WIDTH'(LSTM_LAT - 1);
  localparam logic [WIDTH-1:0] STEP_LAST = WIDTH'(NUM_ITERATIONS - 1);

  state_t           state, state_nxt;
  logic [WIDTH-1:0] addr_q, addr_nxt;
  logic [WIDTH-1:0] step_q, step_nxt;
  logic [WIDTH-1:0] elem_q, elem_nxt;
  logic [WIDTH-1:0] lat_q, lat_nxt;
  logic             sel_q, sel_nxt;
  logic             pend_q, pend_nxt;

  // State and counter registers; everything returns to zero on rst.
  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= IDLE;
      addr_q <= '0;
      step_q <= '0;
      elem_q <= '0;
      lat_q  <= '0;
      sel_q  <= 1'b0;
      pend_q <= 1'b0;
    end else begin
      state  <= state_nxt;
      addr_q <= addr_nxt;
      step_q <= step_nxt;
      elem_q <= elem_nxt;
      lat_q  <= lat_nxt;
      sel_q  <= sel_nxt;
      pend_q <= pend_nxt;
    end
  end

  // Next-state, counter updates and weight-select hand-over.
  always_comb begin
    state_nxt = state;
    addr_nxt  = addr_q;
    step_nxt  = step_q;
    elem_nxt  = elem_q;
    lat_nxt   = lat_q;
    sel_nxt   = sel_q;
    pend_nxt  = pend_q;

    case (state)
      IDLE: begin
        if (bus.i_start && !bus.i_abort) begin
          state_nxt = LOAD;
        end
      end
      LOAD: begin
        // The address stays on the last element through SETTLE and CAPTURE.
        if (elem_q == ELEM_LAST) begin
          state_nxt = SETTLE;
          lat_nxt   = '0;
        end else begin
          elem_nxt = elem_q + 1'b1;
          addr_nxt = addr_q + 1'b1;
        end
      end
      SETTLE: begin
        if (lat_q == LAT_LAST) begin
          state_nxt = CAPTURE;
        end else begin
          lat_nxt = lat_q + 1'b1;
        end
      end
      CAPTURE: begin
        if (step_q == STEP_LAST) begin
          state_nxt = DONE;
        end else begin
          // Next step's base address is exactly one past the last element loaded.
          state_nxt = LOAD;
          step_nxt  = step_q + 1'b1;
          elem_nxt  = '0;
          addr_nxt  = addr_q + 1'b1;
        end
      end
      DONE: begin
        state_nxt = IDLE;
        step_nxt  = '0;
        addr_nxt  = '0;
        elem_nxt  = '0;
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase

    // Abort from any busy state drops straight to IDLE with counters cleared.
    if (state != IDLE && bus.i_abort) begin
      state_nxt = IDLE;
      step_nxt  = '0;
      elem_nxt  = '0;
      addr_nxt  = '0;
      lat_nxt   = '0;
    end

    // Swap weight source only on an IDLE boundary so a run never sees it change.
    if (pend_q && (state == IDLE || state_nxt == IDLE)) begin
      sel_nxt  = 1'b1;
      pend_nxt = 1'b0;
    end
    if (bus.i_upd) begin
      pend_nxt = 1'b1;
    end
  end

  // Strobes decoded from the registered state; abort masks the end-of-step and end-of-run pulses.
  always_comb begin
    bus.o_addr     = addr_q;
    bus.o_step     = step_q;
    bus.o_sel      = sel_q;
    bus.o_shift_en = (state == LOAD);
    bus.o_busy     = (state != IDLE);
    bus.o_commit   = (state == CAPTURE) && !bus.i_abort;
    bus.o_h_valid  = (state == CAPTURE) && !bus.i_abort;
    bus.o_done     = (state == DONE) && !bus.i_abort;
  end

endmodule

// File: tb/tb_lstm_seq_ctrl.sv
// Bench for lstm_seq_ctrl: directed test-plan scenarios plus random control traffic,
// each cycle compared against a run-position model (cycle count since start).
module tb_lstm_seq_ctrl;
  localparam int W       = 32;
  localparam int NUM     = 69;
  localparam int ITER    = 8;
  localparam int LAT     = 4;
  localparam int P       = NUM + LAT;
  localparam int RUN_LEN = ITER * P + 1;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  lstm_seq_ctrl_if #(.WIDTH(W)) mif ();
  lstm_seq_ctrl_if #(.WIDTH(W)) cif ();

  lstm_seq_ctrl #(.WIDTH(W), .NUM(NUM), .NUM_ITERATIONS(ITER), .LSTM_LAT(LAT)) dut (
    .clk (clk),
    .rst (rst),
    .bus (mif)
  );

  lstm_seq_ctrl #(.WIDTH(W), .NUM(2), .NUM_ITERATIONS(1), .LSTM_LAT(1)) dut_c (
    .clk (clk),
    .rst (rst),
    .bus (cif)
  );

  int n_vec = 0;
  int n_err = 0;
  int cyc   = 0;

  // Reference model: idle/running, position t within the run (1 = first LOAD cycle).
  bit m_busy = 1'b0;
  bit m_sel  = 1'b0;
  bit m_pend = 1'b0;
  int m_t    = 0;

  // Event log for directed checks.
  int   hv_first, hv_cnt, sh_cnt, done_cyc, gap_load;
  logic last_sel, last_busy, prev_shift;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s cyc=%0d got=%0d exp=%0d", tag, cyc, got, exp);
    end
  endtask

  task automatic clr_log();
    hv_first = -1;
    hv_cnt   = 0;
    sh_cnt   = 0;
    done_cyc = -1;
    gap_load = -1;
  endtask

  task automatic compare(input logic a);
    logic        e_shift, e_commit, e_done, e_busy;
    logic [31:0] e_addr, e_step;
    bit          as_valid;
    int          s, r;
    e_shift  = 1'b0;
    e_commit = 1'b0;
    e_done   = 1'b0;
    e_busy   = m_busy;
    e_addr   = 32'd0;
    e_step   = 32'd0;
    as_valid = 1'b1;
    if (m_busy) begin
      if (m_t == RUN_LEN) begin
        e_done   = !a;
        as_valid = 1'b0;
      end else begin
        s      = (m_t - 1) / P;
        r      = (m_t - 1) % P;
        e_step = 32'(s);
        if (r < NUM - 1) begin
          e_shift = 1'b1;
          e_addr  = 32'(s * (NUM - 1) + r);
        end else begin
          e_addr = 32'(s * (NUM - 1) + NUM - 2);
          if (r == P - 1) e_commit = !a;
        end
      end
    end
    chk("busy",     32'(mif.o_busy),     32'(e_busy));
    chk("shift_en", 32'(mif.o_shift_en), 32'(e_shift));
    chk("commit",   32'(mif.o_commit),   32'(e_commit));
    chk("h_valid",  32'(mif.o_h_valid),  32'(e_commit));
    chk("done",     32'(mif.o_done),     32'(e_done));
    chk("sel",      32'(mif.o_sel),      32'(m_sel));
    if (as_valid) begin
      chk("addr", mif.o_addr, e_addr);
      chk("step", mif.o_step, e_step);
    end
  endtask

  task automatic model_step(input logic s, input logic a, input logic u, input logic r);
    bit nb;
    int nt;
    if (r) begin
      m_busy = 1'b0;
      m_t    = 0;
      m_sel  = 1'b0;
      m_pend = 1'b0;
    end else begin
      nb = m_busy;
      nt = m_t;
      if (m_busy) begin
        if (a || m_t == RUN_LEN) nb = 1'b0;
        else nt = m_t + 1;
      end else if (s && !a) begin
        nb = 1'b1;
        nt = 1;
      end
      if (m_pend && (!m_busy || !nb)) begin
        m_sel  = 1'b1;
        m_pend = 1'b0;
      end
      if (u) m_pend = 1'b1;
      m_busy = nb;
      m_t    = nt;
    end
  endtask

  task automatic tick(input logic s, input logic a, input logic u, input logic r);
    @(negedge clk);
    rst         = r;
    mif.i_start = s;
    mif.i_abort = a;
    mif.i_upd   = u;
    #1;
    compare(a);
    if (mif.o_h_valid) begin
      hv_cnt++;
      if (hv_first < 0) hv_first = cyc;
    end
    if (mif.o_shift_en) sh_cnt++;
    if (mif.o_shift_en && !prev_shift && done_cyc >= 0 && gap_load < 0) gap_load = cyc;
    if (mif.o_done) done_cyc = cyc;
    prev_shift = mif.o_shift_en;
    last_sel   = mif.o_sel;
    last_busy  = mif.o_busy;
    @(posedge clk);
    model_step(s, a, u, r);
    cyc++;
  endtask

  logic [3:0] cexp [5];

  initial begin
    mif.i_start = 1'b0;
    mif.i_abort = 1'b0;
    mif.i_upd   = 1'b0;
    cif.i_start = 1'b0;
    cif.i_abort = 1'b0;
    cif.i_upd   = 1'b0;
    prev_shift  = 1'b0;
    clr_log();
    @(posedge clk);

    // Reset then nominal run started at cycle 10, weight update mid-run at 200.
    tick(1'b0, 1'b0, 1'b0, 1'b1);
    while (cyc < 10) tick(1'b0, 1'b0, 1'b0, 1'b0);
    clr_log();
    tick(1'b1, 1'b0, 1'b0, 1'b0);
    while (cyc <= 596) tick(1'b0, 1'b0, (cyc == 200), 1'b0);
    chk("first_h_valid", 32'(hv_first), 32'd83);
    chk("h_valid_count", 32'(hv_cnt),   32'd8);
    chk("shift_count",   32'(sh_cnt),   32'd544);
    chk("done_cycle",    32'(done_cyc), 32'd595);
    chk("sel_after_run", 32'(last_sel), 32'd1);

    // Second run on back-prop weights.
    tick(1'b1, 1'b0, 1'b0, 1'b0);
    repeat (RUN_LEN + 2) tick(1'b0, 1'b0, 1'b0, 1'b0);

    // Abort during step 3 SETTLE, then restart from address 0.
    tick(1'b1, 1'b0, 1'b0, 1'b0);
    repeat (3 * P + NUM - 1) tick(1'b0, 1'b0, 1'b0, 1'b0);
    tick(1'b0, 1'b1, 1'b0, 1'b0);
    clr_log();
    repeat (20) tick(1'b0, 1'b0, 1'b0, 1'b0);
    chk("commits_after_abort", 32'(hv_cnt),   32'd0);
    chk("done_after_abort",    32'(done_cyc), 32'hFFFF_FFFF);
    tick(1'b1, 1'b0, 1'b0, 1'b0);
    repeat (5) tick(1'b0, 1'b0, 1'b0, 1'b0);
    tick(1'b0, 1'b1, 1'b0, 1'b0);

    // Start and abort together in IDLE.
    tick(1'b1, 1'b1, 1'b0, 1'b0);
    tick(1'b0, 1'b0, 1'b0, 1'b0);
    chk("start_abort_idle", 32'(last_busy), 32'd0);

    // Start held high: back-to-back runs with one idle cycle between.
    clr_log();
    repeat (1000) tick(1'b1, 1'b0, 1'b0, 1'b0);
    chk("restart_gap", 32'(gap_load - done_cyc), 32'd2);
    tick(1'b0, 1'b1, 1'b0, 1'b0);

    // Reset at elem 30 of step 5 after a weight update.
    tick(1'b0, 1'b0, 1'b1, 1'b0);
    repeat (3) tick(1'b0, 1'b0, 1'b0, 1'b0);
    tick(1'b1, 1'b0, 1'b0, 1'b0);
    repeat (5 * P + 30) tick(1'b0, 1'b0, 1'b0, 1'b0);
    tick(1'b0, 1'b0, 1'b0, 1'b1);
    tick(1'b0, 1'b0, 1'b0, 1'b0);
    chk("sel_after_reset", 32'(last_sel), 32'd0);

    // Random control traffic.
    repeat (15000) begin
      tick(($urandom_range(0, 19) == 0), ($urandom_range(0, 1499) == 0),
           ($urandom_range(0, 399) == 0), ($urandom_range(0, 5999) == 0));
    end

    // Smallest parameter set: one load, one settle, capture, done.
    rst     = 1'b0;
    cexp[0] = 4'b1001;
    cexp[1] = 4'b0001;
    cexp[2] = 4'b0101;
    cexp[3] = 4'b0011;
    cexp[4] = 4'b0000;
    @(negedge clk);
    cif.i_start = 1'b1;
    @(negedge clk);
    cif.i_start = 1'b0;
    for (int t = 0; t < 5; t++) begin
      #1;
      chk($sformatf("corner_t%0d", t + 1),
          32'({cif.o_shift_en, cif.o_commit, cif.o_done, cif.o_busy}), 32'(cexp[t]));
      chk($sformatf("corner_hv_t%0d", t + 1), 32'(cif.o_h_valid), 32'(cexp[t][2]));
      if (t == 0) chk("corner_addr", cif.o_addr, 32'd0);
      @(negedge clk);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule

// File: doc/lstm_seq_ctrl.md
# lstm_seq_ctrl

Sequencer for the LSTM forward-propagation array. It drives the input-memory address, the input shift-register enable and the cell's state-commit strobe. Together these step the cell through `NUM_ITERATIONS` timesteps of `NUM-1` input words each. It also owns the weight-source select `sel`, which switches the cell from power-on weight memories to back-propagation-supplied weights only between runs. It replaces the free-running input address counter and sits between the top-level array, the input memory, the shift register and the `lstm` cell.

## Interface
- `WIDTH`, 32, width of address and step outputs
- `NUM`, 69, weight-vector length; inputs per timestep = `NUM-1`
- `NUM_ITERATIONS`, 8, timesteps per run
- `LSTM_LAT`, 4, settle cycles for the combinational cell after the last shift, ≥1

- `clk` in 1: single clock, rising edge
- `rst` in 1: reset, synchronous, active-high
- `i_start` in 1: run request, sampled in IDLE only
- `i_abort` in 1: terminate the current run
- `i_upd` in 1: pulse; back-prop weights are valid on the `i_w_*`/`i_b_*` inputs
- `o_addr` out `WIDTH`: input-memory address
- `o_shift_en` out 1: shift-register shift enable
- `o_commit` out 1: cell c/h register commit strobe
- `o_h_valid` out 1: `o_h` of the cell is valid for timestep `o_step`
- `o_step` out `WIDTH`: current timestep index
- `o_sel` out 1: weight source; 0 = memory, 1 = back-prop ports
- `o_busy` out 1: run in progress
- `o_done` out 1: one-cycle end-of-run pulse

## Operation
- The FSM has five states: IDLE, LOAD, SETTLE, CAPTURE and DONE.
- **IDLE**
  - If `i_start`=1 and `i_abort`=0, go to LOAD.
  - Otherwise stay in IDLE.
- **LOAD**, `NUM-1` cycles
  - `o_shift_en`=1 on every cycle.
  - `o_addr` = `o_step*(NUM-1) + elem`, where `elem` counts 0..`NUM-2`.
  - After `elem`=`NUM-2`, go to SETTLE.
- **SETTLE**, `LSTM_LAT` cycles
  - All strobes are 0.
  - `o_addr` holds its last value.
- **CAPTURE**, 1 cycle
  - `o_commit`=1 and `o_h_valid`=1.
  - If `o_step`=`NUM_ITERATIONS-1`, go to DONE.
  - Otherwise increment `o_step`, clear `elem`, and go to LOAD.
- **DONE**, 1 cycle
  - `o_done`=1.
  - Clear `o_step` and `o_addr` to 0, then go to IDLE.
- `o_busy` is 1 in LOAD, SETTLE, CAPTURE and DONE.
- Address arithmetic is unsigned, `WIDTH` bits.
  - The maximum address is `NUM_ITERATIONS*(NUM-1)-1`, which is 543 with default parameters.
  - `o_addr` never wraps within a run.
- **Weight select**
  - `i_upd` sets `upd_pending` in any state.
  - While in IDLE with `upd_pending`=1: set `o_sel`=1 and clear `upd_pending`. `o_sel` therefore never changes while `o_busy`=1.
  - `o_sel` stays 1 until `rst`; it is never cleared by a run.
- **Abort**
  - `i_abort`=1 in any busy state forces IDLE on the next edge.
  - `o_step`, `elem` and `o_addr` are cleared to 0, and no `o_done` pulse is issued.
  - `upd_pending` is kept.
- **Simultaneous events**
  - `i_start` while busy is ignored; it is not queued.
  - `i_start` and `i_abort` together in IDLE: abort wins and the FSM stays in IDLE.
  - `i_abort` in CAPTURE suppresses `o_commit` and `o_h_valid` on that cycle.
  - `i_upd` in DONE: the pending flag is applied in the following IDLE cycle.

## Timing
- All outputs are registered, apart from a decode of the registered state.
- **Reset**
  - `rst` at any time returns the FSM to IDLE on the next edge. A mid-run reset leaves the shift register's contents undefined to this block.
  - Reset values:
    - 0: `o_addr`, `o_step`, `o_shift_en`, `o_commit`, `o_h_valid`, `o_busy`, `o_done`, `o_sel`
    - cleared: `upd_pending`
- Let `i_start` be sampled at edge k, with the FSM in IDLE.
  - LOAD occupies cycles k+1..k+`NUM-1`, with addresses 0..`NUM-2`.
  - Memory read data for address `a` is presented to the shift register on the same cycle, since the memory is combinational.
  - SETTLE follows for `LSTM_LAT` cycles.
  - CAPTURE for step s falls at cycle k+`NUM`+`LSTM_LAT`+s*P, where the period P = `NUM`+`LSTM_LAT` = 73 with defaults.
  - DONE falls at cycle k+1+`NUM_ITERATIONS`*P = k+585.
- Earliest restart: `i_start` can be accepted 1 cycle after DONE.

## Test plan
- **Nominal run:** `rst` then `i_start` at cycle 10.
  - `o_shift_en` high for cycles 11–78, with `o_addr` 0..67.
  - `o_h_valid` at cycles 83, 156, …, 594, with `o_step` 0..7.
  - `o_done` at cycle 595; `o_busy` low at 596.
  - Step 1 LOAD addresses are 68..135.
- **Deferred weight update:** `i_upd` at cycle 200 mid-run.
  - `o_sel` stays 0 through DONE and becomes 1 in the first IDLE cycle after the run.
  - A second `i_start` runs with `o_sel`=1 throughout.
- **Abort in SETTLE:** `i_abort` during step 3 SETTLE.
  - Next cycle: IDLE, `o_step`=0, `o_addr`=0.
  - No `o_done` and no further `o_commit`.
  - A new `i_start` begins again at address 0.
- **Start collisions:**
  - `i_start` held high for 1000 cycles produces back-to-back runs with exactly one idle cycle between each DONE and the next LOAD.
  - `i_start` and `i_abort` high together in IDLE leave `o_busy` at 0.
- **Reset mid-LOAD:** `rst` at `elem`=30 of step 5.
  - All outputs return to their reset values on the next edge, including `o_sel`=0 after a prior `i_upd`.
- **Parameter corner:** `NUM`=2, `NUM_ITERATIONS`=1, `LSTM_LAT`=1.
  - One LOAD cycle with `o_addr`=0.
  - CAPTURE at k+3, DONE at k+4.
